// File: rtl/psg_stereo_mixer.sv
// Time-multiplexed stereo mixer for PSG tone channels: one channel per cycle, per-side pan gains, scaled output.
// Latency CH+1 cycles from accepted ce_sample to valid; ce_sample while busy is dropped and flagged by overrun.
// Optional macro PSG_MIX_SATURATE_EN: clamp out-of-range results to all-ones instead of wrapping.
module psg_stereo_mixer #(
    parameter int CH     = 3,
    parameter int IN_W   = 8,
    parameter int GAIN_W = 4,
    parameter int OUT_W  = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ce_sample,
    input  logic [CH*IN_W-1:0]     ch_in,
    input  logic [1:0]             mode,
    input  logic [CH*GAIN_W-1:0]   pan_l,
    input  logic [CH*GAIN_W-1:0]   pan_r,
    output logic [OUT_W-1:0]       audio_l,
    output logic [OUT_W-1:0]       audio_r,
    output logic                   valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int IDX_W = $clog2(CH);
    localparam int PW    = IN_W + GAIN_W;
    localparam int AW    = IN_W + GAIN_W + IDX_W;
    localparam int S     = OUT_W - IN_W - GAIN_W - 1;
    localparam int SW    = OUT_W + IDX_W;

    localparam logic [GAIN_W-1:0] GF = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic [GAIN_W-1:0] GH = {2'b01, {(GAIN_W-2){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MIX,
        S_OUT
    } state_t;

    state_t                 state_q;
    logic [CH*IN_W-1:0]     ch_q;
    logic [1:0]             mode_q;
    logic [CH*GAIN_W-1:0]   pan_l_q;
    logic [CH*GAIN_W-1:0]   pan_r_q;
    logic [IDX_W-1:0]       idx_q;
    logic [AW-1:0]          acc_l_q;
    logic [AW-1:0]          acc_r_q;
    logic [OUT_W-1:0]       audio_l_q;
    logic [OUT_W-1:0]       audio_r_q;
    logic                   valid_q;
    logic                   busy_q;

    logic [IN_W-1:0]        cur_ch;
    logic [GAIN_W-1:0]      gl;
    logic [GAIN_W-1:0]      gr;
    logic [PW-1:0]          prod_l;
    logic [PW-1:0]          prod_r;
    logic [AW-1:0]          acc_l_d;
    logic [AW-1:0]          acc_r_d;

    // Scaled sum is at most SW-1 bits wide, so the top IDX_W bits flag overflow.
    function automatic logic [OUT_W-1:0] scale(input logic [AW-1:0] acc);
`ifdef PSG_MIX_SATURATE_EN
        logic [SW-1:0] w;
        w = SW'(acc) << S;
        return (|w[SW-1:OUT_W]) ? {OUT_W{1'b1}} : w[OUT_W-1:0];
`else
        return OUT_W'(acc) << S;
`endif
    endfunction

    always_comb begin
        gl = GH;
        gr = GH;
        case (mode_q)
            2'd0: begin
                gl = GF;
                gr = GF;
            end
            2'd1: begin
                if (int'(idx_q) == 0) begin
                    gl = GF;
                    gr = '0;
                end else if (int'(idx_q) == 2) begin
                    gl = '0;
                    gr = GF;
                end
            end
            2'd2: begin
                if (int'(idx_q) == 0) begin
                    gl = GF;
                    gr = '0;
                end else if (int'(idx_q) == 1) begin
                    gl = '0;
                    gr = GF;
                end
            end
            default: begin
                gl = pan_l_q[int'(idx_q)*GAIN_W +: GAIN_W];
                gr = pan_r_q[int'(idx_q)*GAIN_W +: GAIN_W];
            end
        endcase
    end

    assign cur_ch  = ch_q[int'(idx_q)*IN_W +: IN_W];
    assign prod_l  = PW'(cur_ch) * PW'(gl);
    assign prod_r  = PW'(cur_ch) * PW'(gr);
    assign acc_l_d = acc_l_q + AW'(prod_l);
    assign acc_r_d = acc_r_q + AW'(prod_r);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            mode_q    <= '0;
            pan_l_q   <= '0;
            pan_r_q   <= '0;
            idx_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ce_sample) begin
                        ch_q    <= ch_in;
                        mode_q  <= mode;
                        pan_l_q <= pan_l;
                        pan_r_q <= pan_r;
                        acc_l_q <= '0;
                        acc_r_q <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_MIX;
                    end
                end
                S_MIX: begin
                    acc_l_q <= acc_l_d;
                    acc_r_q <= acc_r_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    // Output registers load with the final sum so valid lands in the OUT cycle.
                    if (idx_q == IDX_W'(CH-1)) begin
                        audio_l_q <= scale(acc_l_d);
                        audio_r_q <= scale(acc_r_d);
                        valid_q   <= 1'b1;
                        state_q   <= S_OUT;
                    end
                end
                S_OUT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign audio_l = audio_l_q;
    assign audio_r = audio_r_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign overrun = ce_sample && (state_q != S_IDLE);

endmodule
